// File: rtl/pulse_period_meter.sv
// Period meter: synchronises a raw pulse, counts prescaled ticks between rising edges
// and averages 2^AVG_LOG2 periods per result. Optional level filter: PULSE_DEGLITCH_EN.
module pulse_period_meter #(
  parameter int COUNT_W         = 16,
  parameter int AVG_LOG2        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [2:0]         clk_config,
  input  logic               input_pulse,
  output logic [COUNT_W-1:0] period,
  output logic               period_valid,
  output logic               timeout,
  output logic               busy
);

  localparam int SUM_W = COUNT_W + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t               r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_levelPrev;
  logic [6:0]           r_presc;
  logic [COUNT_W-1:0]   r_count;
  logic [SUM_W-1:0]     r_sum;
  logic [IDX_W-1:0]     r_idx;
  logic [2:0]           r_cfgPrev;
  logic [COUNT_W-1:0]   r_period;
  logic                 r_periodValid;
  logic                 r_timeout;
  logic                 r_busy;

  logic                 w_syncOut;
  logic                 w_level;
  logic                 w_edge;
  logic [6:0]           w_prescLast;
  logic                 w_tick;
  logic [COUNT_W:0]     w_countInc;
  logic [COUNT_W-1:0]   w_sample;
  logic [SUM_W-1:0]     w_sumNext;
  logic                 w_countSat;
  logic                 w_cfgChanged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], input_pulse};
  end

  assign w_syncOut = r_sync[SYNC_STAGES-1];

`ifdef PULSE_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;
  logic            r_filtLevel;
  logic [DG_W-1:0] r_dgCnt;

  // The filtered level follows the synchroniser only once the new level has held for the full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filtLevel <= 1'b0;
      r_dgCnt     <= '0;
    end else if (w_syncOut != r_filtLevel) begin
      if (r_dgCnt == DG_W'(DEGLITCH_CYCLES - 1)) begin
        r_filtLevel <= w_syncOut;
        r_dgCnt     <= '0;
      end else begin
        r_dgCnt <= r_dgCnt + DG_W'(1);
      end
    end else begin
      r_dgCnt <= '0;
    end
  end

  assign w_level = r_filtLevel;
`else
  assign w_level = w_syncOut;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_levelPrev <= 1'b0;
    else        r_levelPrev <= w_level;
  end

  assign w_edge = w_level & ~r_levelPrev;

  assign w_prescLast = 7'((8'd1 << clk_config) - 8'd1);
  assign w_tick      = (r_presc == w_prescLast);

  // Restarting the prescaler on each edge keeps tick phase aligned to the period start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_presc <= '0;
    else if (w_edge || w_tick)  r_presc <= '0;
    else                        r_presc <= r_presc + 7'd1;
  end

  assign w_countInc = {1'b0, r_count} + (COUNT_W+1)'(w_tick);
  assign w_sample   = w_countInc[COUNT_W] ? CNT_MAX : w_countInc[COUNT_W-1:0];
  assign w_sumNext  = r_sum + SUM_W'(w_sample);
  assign w_countSat = (r_count == CNT_MAX);
  assign w_cfgChanged = (clk_config != r_cfgPrev);

  // Control FSM; enable dominates, then a prescale change, then edge before saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_sum         <= '0;
      r_idx         <= '0;
      r_cfgPrev     <= '0;
      r_period      <= '0;
      r_periodValid <= 1'b0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_periodValid <= 1'b0;
      r_cfgPrev     <= clk_config;
      if (!enable) begin
        r_state   <= IDLE;
        r_count   <= '0;
        r_sum     <= '0;
        r_idx     <= '0;
        r_timeout <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_count <= '0;
            if (w_edge) begin
              r_state <= MEASURE;
              r_sum   <= '0;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
          MEASURE: begin
            if (w_cfgChanged) begin
              r_state <= IDLE;
              r_count <= '0;
              r_sum   <= '0;
              r_idx   <= '0;
              r_busy  <= 1'b0;
            end else if (w_edge) begin
              r_count <= '0;
              if (r_idx == IDX_LAST) begin
                r_period      <= COUNT_W'(w_sumNext >> AVG_LOG2);
                r_periodValid <= 1'b1;
                r_sum         <= '0;
                r_idx         <= '0;
              end else begin
                r_sum <= w_sumNext;
                r_idx <= r_idx + IDX_W'(1);
              end
            end else if (w_countSat) begin
              r_state   <= TIMEOUT;
              r_count   <= '0;
              r_sum     <= '0;
              r_idx     <= '0;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
            end else if (w_tick) begin
              r_count <= r_count + COUNT_W'(1);
            end
          end
          TIMEOUT: begin
            r_count <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            if (w_edge) begin
              r_state   <= MEASURE;
              r_timeout <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_periodValid;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

endmodule
